dmem_responder: RTL and testbench

- Data-memory responder: the target end of the core's load/store port.
- Accepts one request at a time over a valid/ready handshake.
- Waits a configurable number of cycles, then performs the word/half/byte access against an internal word array.
- Returns a response with RISC-V load extension and an error flag.
- Lets the single-cycle core be replaced by a multicycle core and tested against realistic memory latency.

---
 rtl/dmem_responder.sv | 191 +++++++++++++++++++
 tb/tb_dmem_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Data-memory target for the core load/store port. One request at
//            a time, fixed wait latency, RISC-V load extension, error flag.
//            Optional DMEM_STATS_EN macro adds saturating access counters.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_size,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errs
`endif
);

    localparam int         c_aw     = $clog2(DEPTH);
    localparam logic [3:0] c_lat_m1 = 4'((LATENCY == 0) ? 0 : LATENCY - 1);

    localparam logic [1:0] c_idle   = 2'd0;
    localparam logic [1:0] c_wait   = 2'd1;
    localparam logic [1:0] c_access = 2'd2;
    localparam logic [1:0] c_resp   = 2'd3;

    logic [1:0]  r_state, w_next;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr, r_wdata;
    logic [2:0]  r_size;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [31:0] r_mem [DEPTH];

    logic [c_aw-1:0] w_idx;
    logic [31:0]     w_word, w_load, w_lanes, w_merged;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [3:0]      w_be;
    logic            w_size_bad, w_misalign, w_range, w_err;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_idle;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle:   if (req_valid) w_next = (LATENCY == 0) ? c_access : c_wait;
            c_wait:   if (r_cnt == 4'd0) w_next = c_access;
            c_access: w_next = c_resp;
            c_resp:   if (rsp_ready) w_next = c_idle;
            default:  w_next = c_idle;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = (r_state == c_idle);
        rsp_valid = (r_state == c_resp);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_size  <= 3'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: if (req_valid) begin
                    r_we    <= req_we;
                    r_addr  <= req_addr;
                    r_wdata <= req_wdata;
                    r_size  <= req_size;
                    r_cnt   <= c_lat_m1;
                end
                c_wait: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                c_access: begin
                    r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                    r_err   <= w_err;
                end
                default: ;
            endcase
        end
    end

    // Error classification; upper address bits must be zero, no aliasing
    always_comb begin
        case (r_size)
            3'b000, 3'b001, 3'b010: w_size_bad = 1'b0;
            3'b100, 3'b101:         w_size_bad = r_we;
            default:                w_size_bad = 1'b1;
        endcase
        w_misalign = ((r_size[1:0] == 2'b01) && r_addr[0]) ||
                     ((r_size[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
        w_range    = |r_addr[31:c_aw+2];
        w_err      = w_size_bad || w_misalign || w_range;
    end

    assign w_idx  = r_addr[c_aw+1:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        case (r_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = r_addr[1] ? w_word[31:16] : w_word[15:0];
        case (r_size)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // Replicate store data across lanes, then merge under byte enables
    always_comb begin
        case (r_size[1:0])
            2'b00: begin
                w_be    = 4'b0001 << r_addr[1:0];
                w_lanes = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
                w_lanes = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_lanes = r_wdata;
            end
        endcase
        w_merged = w_word;
        for (int i = 0; i < 4; i++)
            if (w_be[i]) w_merged[8*i +: 8] = w_lanes[8*i +: 8];
    end

    always_ff @(posedge clk) begin
        if (r_state == c_access && r_we && !w_err)
            r_mem[w_idx] <= w_merged;
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_loads  <= 16'd0;
            stat_stores <= 16'd0;
            stat_errs   <= 16'd0;
        end else if (r_state == c_access) begin
            if (w_err) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (r_we) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed vector bench for dmem_responder (DEPTH=64, LATENCY=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [2:0] c_b  = 3'b000;
    localparam logic [2:0] c_h  = 3'b001;
    localparam logic [2:0] c_w  = 3'b010;
    localparam logic [2:0] c_bu = 3'b100;
    localparam logic [2:0] c_hu = 3'b101;
    localparam int         c_lat = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_size = 3'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

    dmem_responder #(.DEPTH(64), .LATENCY(c_lat)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_size  (req_size),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_STATS_EN
        ,
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  size;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] size, input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request and return once it has been accepted
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [2:0] size, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
        for (int i = 0; i < 40; i++) begin
            if (req_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        req_valid = 1'b0;
    endtask

    // Cycle count from acceptance (acceptance edge ends cycle 0)
    task automatic wait_rsp(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
            lat++;
        end
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] size, output logic [31:0] rdata, output logic err,
                       output int lat);
        bit ok_a, ok_r;
        rdata = 32'hXXXXXXXX;
        err   = 1'bx;
        issue(we, addr, wdata, size, ok_a);
        if (!ok_a) begin
            chk("accept_timeout", 32'd0, 32'd1);
            lat = -1;
        end else begin
            wait_rsp(lat, ok_r);
            if (!ok_r) chk("rsp_timeout", 32'd0, 32'd1);
            else begin
                rdata = rsp_rdata;
                err   = rsp_err;
                tick();
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bit          ok;

        add(1, 32'h000, 32'hA5A5A5A5, c_w,  32'h0,        0);
        add(1, 32'h010, 32'hDEADBEEF, c_w,  32'h0,        0);
        add(0, 32'h010, 32'h0,        c_w,  32'hDEADBEEF, 0);
        add(1, 32'h013, 32'h00000080, c_b,  32'h0,        0);
        add(0, 32'h013, 32'h0,        c_b,  32'hFFFFFF80, 0);
        add(0, 32'h013, 32'h0,        c_bu, 32'h00000080, 0);
        add(0, 32'h010, 32'h0,        c_w,  32'h80ADBEEF, 0);
        add(1, 32'h010, 32'h00001234, c_h,  32'h0,        0);
        add(0, 32'h010, 32'h0,        c_hu, 32'h00001234, 0);
        add(0, 32'h012, 32'h0,        c_w,  32'h0,        1);
        add(1, 32'h011, 32'h00005555, c_h,  32'h0,        1);
        add(0, 32'h010, 32'h0,        c_w,  32'h80AD1234, 0);
        add(0, 32'h010, 32'h0,        3'b011, 32'h0,      1);
        add(1, 32'h100, 32'h77777777, c_w,  32'h0,        1);
        add(0, 32'h100, 32'h0,        c_w,  32'h0,        1);
        add(0, 32'h000, 32'h0,        c_w,  32'hA5A5A5A5, 0);
        add(1, 32'h014, 32'h11223344, c_w,  32'h0,        0);
        add(1, 32'h016, 32'h0000F00D, c_h,  32'h0,        0);
        add(0, 32'h016, 32'h0,        c_h,  32'hFFFFF00D, 0);
        add(0, 32'h016, 32'h0,        c_hu, 32'h0000F00D, 0);
        add(1, 32'h015, 32'h0000007F, c_b,  32'h0,        0);
        add(0, 32'h015, 32'h0,        c_b,  32'h0000007F, 0);
        add(0, 32'h014, 32'h0,        c_w,  32'hF00D7F44, 0);
        add(1, 32'h014, 32'h0,        c_bu, 32'h0,        1);
        add(1, 32'h014, 32'h0,        c_hu, 32'h0,        1);
        add(0, 32'h014, 32'h0,        c_w,  32'hF00D7F44, 0);
        add(1, 32'h0FC, 32'hCAFEF00D, c_w,  32'h0,        0);
        add(0, 32'h0FC, 32'h0,        c_w,  32'hCAFEF00D, 0);
        add(0, 32'h0FE, 32'h0,        c_h,  32'hFFFFCAFE, 0);
        add(0, 32'h0FC, 32'h0,        c_b,  32'h0000000D, 0);
        add(0, 32'hFFFFFFFC, 32'h0,   c_w,  32'h0,        1);
        add(0, 32'h010, 32'h0,        3'b111, 32'h0,      1);
        add(0, 32'h013, 32'h0,        c_hu, 32'h0,        1);

        tick(); tick();
        reset = 1'b0;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);

        foreach (vecs[k]) begin
            txn(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].size, rd, er, lat);
            chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
            chk($sformatf("vec%0d_err", k), {31'd0, er}, {31'd0, vecs[k].exp_err});
            chk($sformatf("vec%0d_latency", k), lat, c_lat + 2);
        end

        // Back-pressure: response held, new request ignored until handshake
        rsp_ready = 1'b0;
        issue(0, 32'h010, 32'h0, c_w, ok);
        wait_rsp(lat, ok);
        chk("bp_rsp_arrives", {31'd0, ok}, 32'd1);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h010;
        req_wdata = 32'h99999999; req_size = c_w;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata",     rsp_rdata, 32'h80AD1234);
            chk("bp_err",       {31'd0, rsp_err}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_after_hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_after_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        wait_rsp(lat, ok);
        chk("bp_pending_lat", lat, c_lat + 2);
        tick();
        txn(0, 32'h010, 32'h0, c_w, rd, er, lat);
        chk("bp_pending_written", rd, 32'h99999999);

        // Reset during WAIT discards the store
        txn(1, 32'h020, 32'h0BADF00D, c_w, rd, er, lat);
        txn(0, 32'h020, 32'h0, c_w, rd, er, lat);
        chk("rst_pre_load", rd, 32'h0BADF00D);
        issue(1, 32'h020, 32'h11111111, c_w, ok);
        chk("rst_in_wait_req_ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_async_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_async_rdata",     rsp_rdata, 32'd0);
        chk("rst_async_err",       {31'd0, rsp_err}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        txn(0, 32'h020, 32'h0, c_w, rd, er, lat);
        chk("rst_store_discarded", rd, 32'h0BADF00D);
        chk("rst_store_err",       {31'd0, er}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
